// File: rtl/wb_slave_pkg.sv
// rtl/wb_slave_pkg.sv - shared types and default parameters for the wishbone register file
package wb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        ACK,
        ERR,
        RTY
    } term_t;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_1000;
    localparam int          DEF_DEPTH       = 16;
    localparam int          DEF_WAIT_CYCLES = 1;

endpackage

// File: rtl/wb_slave_regfile_mem.sv
// rtl/wb_slave_regfile_mem.sv - DEPTH x (32 data + 16 tag) storage, byte-enabled write, combinational read
module wb_slave_regfile_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wsel,
    input  logic [31:0]   wdata,
    input  logic [15:0]   wtag,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    output logic [15:0]   rtag
);

    logic [31:0] data_q [DEPTH];
    logic [15:0] tag_q  [DEPTH];

    // Clear hits every entry in the same cycle so reset never needs a sweep.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wsel[b]) begin
                    data_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            if (|wsel) begin
                tag_q[waddr] <= wtag;
            end
        end
    end

    assign rdata = data_q[raddr];
    assign rtag  = tag_q[raddr];

endmodule

// File: rtl/wb_slave_regfile.sv
// rtl/wb_slave_regfile.sv - wishbone slave register file with wait states, error decode and retry
module wb_slave_regfile
    import wb_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          DEPTH       = DEF_DEPTH,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    input  logic [3:0]  SEL_I,
    input  logic [15:0] TGD_I,
    input  logic        busy_i,
    output logic [31:0] DAT_O,
    output logic [15:0] TGD_O,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic        RTY_O
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t      state;
    logic [3:0]  cnt;
    logic        cap_we;
    logic [31:0] cap_adr;
    logic [31:0] cap_dat;
    logic [3:0]  cap_sel;
    logic [15:0] cap_tgd;

    logic [31:0] offs;
    logic        addr_err;
    term_t       term;
    logic        live;
    logic [31:0] rdata;
    logic [15:0] rtag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cap_we  <= 1'b0;
            cap_adr <= '0;
            cap_dat <= '0;
            cap_sel <= '0;
            cap_tgd <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CYC_I && STB_I) begin
                        cap_we  <= WE_I;
                        cap_adr <= ADR_I;
                        cap_dat <= DAT_I;
                        cap_sel <= SEL_I;
                        cap_tgd <= TGD_I;
                        cnt     <= WAIT_LOAD;
                        state   <= (WAIT_CYCLES > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (!CYC_I) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Subtraction is unsigned, so addresses below BASE_ADDR are rejected explicitly rather than wrapping.
    assign offs     = cap_adr - BASE_ADDR;
    assign addr_err = (cap_adr[1:0] != 2'b00) || (cap_adr < BASE_ADDR) || ((offs >> 2) >= DEPTH_W);

    always_comb begin
        term = ACK;
        if (addr_err) begin
            term = ERR;
        end else if (busy_i) begin
            term = RTY;
        end
    end

    // Termination is driven during RESP only while the master still holds CYC_I.
    assign live  = !rst && (state == RESP) && CYC_I;
    assign ACK_O = live && (term == ACK);
    assign ERR_O = live && (term == ERR);
    assign RTY_O = live && (term == RTY);

    assign DAT_O = (ACK_O && !cap_we) ? rdata : 32'h0;
    assign TGD_O = (ACK_O && !cap_we) ? rtag  : 16'h0;

    wb_slave_regfile_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .clr   (rst),
        .we    (ACK_O && cap_we),
        .waddr (offs[AW+1:2]),
        .wsel  (cap_sel),
        .wdata (cap_dat),
        .wtag  (cap_tgd),
        .raddr (offs[AW+1:2]),
        .rdata (rdata),
        .rtag  (rtag)
    );

endmodule

// File: tb/tb_wb_slave_regfile.sv
// tb/tb_wb_slave_regfile.sv - directed table-driven bench for wb_slave_regfile
module tb_wb_slave_regfile;

    localparam int T_NONE = 0;
    localparam int T_ACK  = 1;
    localparam int T_ERR  = 2;
    localparam int T_RTY  = 3;

    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [15:0] tgd;
    logic        busy;

    logic [31:0] dat_o [3];
    logic [15:0] tgd_o [3];
    logic        ack_o [3];
    logic        err_o [3];
    logic        rty_o [3];

    int checks;
    int failures;

    // Instance 0: WAIT_CYCLES=0, instance 1: WAIT_CYCLES=1, instance 2: WAIT_CYCLES=3.
    wb_slave_regfile #(.BASE_ADDR(32'h0000_1000), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr), .DAT_I(dat),
        .SEL_I(sel), .TGD_I(tgd), .busy_i(busy), .DAT_O(dat_o[0]), .TGD_O(tgd_o[0]),
        .ACK_O(ack_o[0]), .ERR_O(err_o[0]), .RTY_O(rty_o[0]));

    wb_slave_regfile #(.BASE_ADDR(32'h0000_1000), .DEPTH(16), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr), .DAT_I(dat),
        .SEL_I(sel), .TGD_I(tgd), .busy_i(busy), .DAT_O(dat_o[1]), .TGD_O(tgd_o[1]),
        .ACK_O(ack_o[1]), .ERR_O(err_o[1]), .RTY_O(rty_o[1]));

    wb_slave_regfile #(.BASE_ADDR(32'h0000_1000), .DEPTH(16), .WAIT_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr), .DAT_I(dat),
        .SEL_I(sel), .TGD_I(tgd), .busy_i(busy), .DAT_O(dat_o[2]), .TGD_O(tgd_o[2]),
        .ACK_O(ack_o[2]), .ERR_O(err_o[2]), .RTY_O(rty_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [15:0] t;
        logic        b;
        int          term;
        logic [31:0] ed;
        logic [15:0] et;
    } vec_t;

    vec_t vecs [19];

    function automatic int term_of(input int k);
        int n;
        n = int'(ack_o[k]) + int'(err_o[k]) + int'(rty_o[k]);
        if (n > 1) return 4;
        if (ack_o[k]) return T_ACK;
        if (err_o[k]) return T_ERR;
        if (rty_o[k]) return T_RTY;
        return T_NONE;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name, input int k);
        chk({name, "_term"}, 32'(term_of(k)), 32'(T_NONE));
        chk({name, "_dat"}, dat_o[k], 32'h0);
        chk({name, "_tgd"}, {16'h0, tgd_o[k]}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [15:0] t, input logic b,
                       output int term, output logic [31:0] rd, output logic [15:0] rt,
                       output int lat);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s; tgd = t; busy = b;
        @(posedge clk);
        term = T_NONE; rd = 32'h0; rt = 16'h0; lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (term_of(k) != T_NONE) begin
                term = term_of(k);
                rd   = dat_o[k];
                rt   = tgd_o[k];
                lat  = i;
                break;
            end
        end
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; busy = 1'b0;
    endtask

    initial begin
        int          term;
        int          lat;
        logic [31:0] rd;
        logic [15:0] rt;
        int          seen;

        checks = 0; failures = 0;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
        tgd = '0; busy = 1'b0;

        vecs[0]  = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 16'h00A5, 1'b0, T_ACK, 32'h0, 16'h0};
        vecs[1]  = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 16'h0,    1'b0, T_ACK, 32'hDEAD_BEEF, 16'h00A5};
        vecs[2]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'h5, 16'h1111, 1'b0, T_ACK, 32'h0, 16'h0};
        vecs[3]  = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 16'h0,    1'b0, T_ACK, 32'hDE34_BE78, 16'h1111};
        vecs[4]  = '{1'b0, 32'h0000_1002, 32'h0,         4'hF, 16'h0,    1'b0, T_ERR, 32'h0, 16'h0};
        vecs[5]  = '{1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 16'h0,    1'b0, T_ERR, 32'h0, 16'h0};
        vecs[6]  = '{1'b0, 32'h0000_1040, 32'h0,         4'hF, 16'h0,    1'b0, T_ERR, 32'h0, 16'h0};
        vecs[7]  = '{1'b0, 32'h0000_1040, 32'h0,         4'hF, 16'h0,    1'b1, T_ERR, 32'h0, 16'h0};
        vecs[8]  = '{1'b1, 32'h0000_1004, 32'hAAAA_5555, 4'hF, 16'h0042, 1'b1, T_RTY, 32'h0, 16'h0};
        vecs[9]  = '{1'b0, 32'h0000_1004, 32'h0,         4'hF, 16'h0,    1'b0, T_ACK, 32'h0, 16'h0};
        vecs[10] = '{1'b1, 32'h0000_1004, 32'hAAAA_5555, 4'hF, 16'h0042, 1'b0, T_ACK, 32'h0, 16'h0};
        vecs[11] = '{1'b0, 32'h0000_1004, 32'h0,         4'hF, 16'h0,    1'b0, T_ACK, 32'hAAAA_5555, 16'h0042};
        vecs[12] = '{1'b1, 32'h0000_1008, 32'hFFFF_FFFF, 4'h0, 16'h7777, 1'b0, T_ACK, 32'h0, 16'h0};
        vecs[13] = '{1'b0, 32'h0000_1008, 32'h0,         4'hF, 16'h0,    1'b0, T_ACK, 32'h0, 16'h0};
        vecs[14] = '{1'b1, 32'h0000_103C, 32'h0BAD_F00D, 4'h8, 16'h00C3, 1'b0, T_ACK, 32'h0, 16'h0};
        vecs[15] = '{1'b0, 32'h0000_103C, 32'h0,         4'h0, 16'h0,    1'b0, T_ACK, 32'h0B00_0000, 16'h00C3};
        vecs[16] = '{1'b1, 32'h0000_1002, 32'hFFFF_FFFF, 4'hF, 16'h9999, 1'b0, T_ERR, 32'h0, 16'h0};
        vecs[17] = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 16'h0,    1'b1, T_RTY, 32'h0, 16'h0};
        vecs[18] = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 16'h0,    1'b0, T_ACK, 32'hDE34_BE78, 16'h1111};

        do_reset();
        for (int k = 0; k < 3; k++) chk_quiet($sformatf("reset_inst%0d", k), k);

        // Table vectors on the single-wait-state instance.
        for (int v = 0; v < 19; v++) begin
            txn(1, vecs[v].w, vecs[v].a, vecs[v].d, vecs[v].s, vecs[v].t, vecs[v].b, term, rd, rt, lat);
            chk($sformatf("vec%0d_term", v), 32'(term), 32'(vecs[v].term));
            chk($sformatf("vec%0d_dat", v), rd, vecs[v].ed);
            chk($sformatf("vec%0d_tgd", v), {16'h0, rt}, {16'h0, vecs[v].et});
            chk($sformatf("vec%0d_lat", v), 32'(lat), 32'd2);
        end

        // Three wait states: full write, then aborted write, then reset mid-wait.
        do_reset();
        txn(2, 1'b1, 32'h0000_1010, 32'h1111_1111, 4'hF, 16'h0033, 1'b0, term, rd, rt, lat);
        chk("w3_write_term", 32'(term), 32'(T_ACK));
        chk("w3_write_lat", 32'(lat), 32'd4);

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_1010; dat = 32'h2222_2222; sel = 4'hF; tgd = 16'h0044;
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        cyc = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (term_of(2) != T_NONE) seen = 1;
        end
        chk("w3_abort_noterm", 32'(seen), 32'd0);
        txn(2, 1'b0, 32'h0000_1010, 32'h0, 4'hF, 16'h0, 1'b0, term, rd, rt, lat);
        chk("w3_abort_rd_term", 32'(term), 32'(T_ACK));
        chk("w3_abort_rd_dat", rd, 32'h1111_1111);
        chk("w3_abort_rd_tgd", {16'h0, rt}, 32'h0000_0033);

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_1010; dat = 32'h3333_3333; sel = 4'hF; tgd = 16'h0055;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_quiet("w3_rst_mid_wait", 2);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (term_of(2) != T_NONE) seen = 1;
        end
        chk("w3_rst_noterm", 32'(seen), 32'd0);
        txn(2, 1'b0, 32'h0000_1010, 32'h0, 4'hF, 16'h0, 1'b0, term, rd, rt, lat);
        chk("w3_rst_rd_term", 32'(term), 32'(T_ACK));
        chk("w3_rst_rd_dat", rd, 32'h0);
        chk("w3_rst_rd_tgd", {16'h0, rt}, 32'h0);

        // Zero wait states, STB_I held: captures in cycles 0,2,4 and ACKs in cycles 1,3,5.
        do_reset();
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_1000; sel = 4'hF;
        dat = 32'h0000_0100; tgd = 16'h0100;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_cycle%0d_term", i), 32'(term_of(0)),
                ((i % 2) == 1) ? 32'(T_ACK) : 32'(T_NONE));
            dat = 32'h0000_0100 + 32'(i);
            tgd = 16'h0100 + 16'(i);
            if (i == 6) begin
                cyc = 1'b0; stb = 1'b0;
            end
        end
        txn(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 16'h0, 1'b0, term, rd, rt, lat);
        chk("b2b_rd_term", 32'(term), 32'(T_ACK));
        chk("b2b_rd_lat", 32'(lat), 32'd1);
        chk("b2b_rd_dat", rd, 32'h0000_0104);
        chk("b2b_rd_tgd", {16'h0, rt}, 32'h0000_0104);

        @(negedge clk);
        chk_quiet("idle_end", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
